// File: rtl/nco_tune_ctrl.sv
// Tuning-word controller: debounced buttons drive a press/hold/auto-repeat FSM
// that steps a saturating target word, offered downstream over valid/ready.
module nco_tune_ctrl #(
  parameter int              WIDTH           = 33,
  parameter logic [WIDTH-1:0] RESET_WORD     = WIDTH'(1),
  parameter int              DEBOUNCE_CYCLES = 270000,
  parameter int              HOLD_CYCLES     = 13500000,
  parameter int              REPEAT_CYCLES   = 2700000,
  parameter int              MAX_SHIFT       = 16
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             btn1,
  input  logic             btn2,
  output logic [WIDTH-1:0] tune_word,
  output logic             tune_valid,
  input  logic             tune_ready,
  output logic [4:0]       step_shift,
  output logic [1:0]       pressed
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [4:0]        SHIFT_MAX = 5'(MAX_SHIFT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_HOLD,
    S_REPEAT,
    S_ZERO,
    S_RELEASE
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] level_vec;
  logic [1:0] level_d_reg;
  logic [1:0] press_edge;

  assign btn_raw = {btn2, btn1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync_meta_reg;
      logic            sync_reg;
      logic            level_reg;
      logic [DB_W-1:0] db_cnt_reg;

      // Buttons are active-low on the board; invert at the first flop.
      always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_meta_reg <= 1'b0;
          sync_reg      <= 1'b0;
          level_reg     <= 1'b0;
          db_cnt_reg    <= '0;
        end else begin
          sync_meta_reg <= ~btn_raw[gi];
          sync_reg      <= sync_meta_reg;
          if (sync_reg == level_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            level_reg  <= sync_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end

      assign level_vec[gi] = level_reg;
    end
  endgenerate

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) level_d_reg <= 2'b00;
    else        level_d_reg <= level_vec;
  end

  assign press_edge = level_vec & ~level_d_reg;

  state_t             state_reg, state_next;
  logic               dir_reg, dir_next;          // 1 = increment (btn2)
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [REP_W-1:0]   rep_cnt_reg, rep_cnt_next;
  logic [4:0]         shift_reg, shift_next;
  logic [WIDTH-1:0]   target_reg, target_next;

  logic [WIDTH-1:0]   step_val;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   inc_word;
  logic [WIDTH-1:0]   dec_word;
  logic [WIDTH-1:0]   stepped_word;
  logic               both_held;
  logic               dir_held;

  // Saturating step in either direction; the extra sum bit flags overflow.
  assign step_val     = WIDTH'(1) << shift_reg;
  assign sum_ext      = {1'b0, target_reg} + {1'b0, step_val};
  assign inc_word     = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
  assign dec_word     = (target_reg < step_val) ? '0 : (target_reg - step_val);
  assign stepped_word = dir_reg ? inc_word : dec_word;
  assign both_held    = &level_vec;
  assign dir_held     = dir_reg ? level_vec[1] : level_vec[0];

  always_comb begin
    state_next    = state_reg;
    dir_next      = dir_reg;
    hold_cnt_next = hold_cnt_reg;
    rep_cnt_next  = rep_cnt_reg;
    shift_next    = shift_reg;
    target_next   = target_reg;
    case (state_reg)
      S_IDLE: begin
        if (both_held) begin
          state_next = S_ZERO;
        end else if (press_edge[1]) begin
          dir_next   = 1'b1;
          state_next = S_STEP;
        end else if (press_edge[0]) begin
          dir_next   = 1'b0;
          state_next = S_STEP;
        end
      end
      S_STEP: begin
        target_next   = stepped_word;
        hold_cnt_next = '0;
        state_next    = S_HOLD;
      end
      S_HOLD: begin
        if (both_held) begin
          state_next = S_ZERO;
        end else if (!dir_held) begin
          shift_next = '0;
          state_next = S_IDLE;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          rep_cnt_next = '0;
          state_next   = S_REPEAT;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      S_REPEAT: begin
        if (both_held) begin
          state_next = S_ZERO;
        end else if (!dir_held) begin
          shift_next = '0;
          state_next = S_IDLE;
        end else if (rep_cnt_reg == REP_LAST) begin
          // The step uses the current exponent; acceleration applies to the next one.
          target_next  = stepped_word;
          rep_cnt_next = '0;
          if (shift_reg < SHIFT_MAX) shift_next = shift_reg + 1'b1;
        end else begin
          rep_cnt_next = rep_cnt_reg + 1'b1;
        end
      end
      S_ZERO: begin
        target_next = '0;
        shift_next  = '0;
        state_next  = S_RELEASE;
      end
      S_RELEASE: begin
        if (level_vec == 2'b00) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      dir_reg      <= 1'b0;
      hold_cnt_reg <= '0;
      rep_cnt_reg  <= '0;
      shift_reg    <= '0;
      target_reg   <= RESET_WORD;
    end else begin
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      hold_cnt_reg <= hold_cnt_next;
      rep_cnt_reg  <= rep_cnt_next;
      shift_reg    <= shift_next;
      target_reg   <= target_next;
    end
  end

  logic [WIDTH-1:0] last_acc_reg;
  logic             acc_seen_reg;   // clear until the first transfer, forcing the reset word out
  logic             transfer;
  logic             offer_needed;

  assign transfer     = tune_valid && tune_ready;
  assign offer_needed = transfer ? (target_reg != tune_word)
                                 : (!acc_seen_reg || (target_reg != last_acc_reg));

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      tune_word    <= RESET_WORD;
      tune_valid   <= 1'b0;
      last_acc_reg <= RESET_WORD;
      acc_seen_reg <= 1'b0;
    end else begin
      if (transfer) begin
        last_acc_reg <= tune_word;
        acc_seen_reg <= 1'b1;
      end
      if (!tune_valid || transfer) begin
        if (offer_needed) begin
          tune_word  <= target_reg;
          tune_valid <= 1'b1;
        end else begin
          tune_valid <= 1'b0;
        end
      end
    end
  end

  assign step_shift = shift_reg;
  assign pressed    = level_vec;

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Directed bench for nco_tune_ctrl with shortened timing constants.
module tb_nco_tune_ctrl;

  logic       in_clk = 1'b0;
  logic       rst_n;
  logic       btn1;
  logic       btn2;
  logic [7:0] tune_word;
  logic       tune_valid;
  logic       tune_ready;
  logic [4:0] step_shift;
  logic [1:0] pressed;

  int checks   = 0;
  int failures = 0;

  logic [7:0] acc_q[$];

  nco_tune_ctrl #(
    .WIDTH           (8),
    .RESET_WORD      (8'h01),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (5),
    .MAX_SHIFT       (3)
  ) dut (
    .in_clk     (in_clk),
    .rst_n      (rst_n),
    .btn1       (btn1),
    .btn2       (btn2),
    .tune_word  (tune_word),
    .tune_valid (tune_valid),
    .tune_ready (tune_ready),
    .step_shift (step_shift),
    .pressed    (pressed)
  );

  always #5 in_clk = ~in_clk;

  // Record every accepted word.
  always @(posedge in_clk) begin
    if (rst_n && tune_valid && tune_ready) acc_q.push_back(tune_word);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Short press: long enough to debounce, released before auto-repeat begins.
  task automatic press(input bit up);
    if (up) btn2 = 1'b0; else btn1 = 1'b0;
    tick(10);
    btn1 = 1'b1;
    btn2 = 1'b1;
    tick(12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    rst_n      = 1'b0;
    btn1       = 1'b1;
    btn2       = 1'b1;
    tune_ready = 1'b1;

    // 1. reset state and publication of the reset word
    tick(3);
    check("rst_valid", 32'(tune_valid), 32'd0);
    check("rst_word", 32'(tune_word), 32'h01);
    check("rst_shift", 32'(step_shift), 32'd0);
    check("rst_pressed", 32'(pressed), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("pub_valid", 32'(tune_valid), 32'd1);
    check("pub_word", 32'(tune_word), 32'h01);
    tick(1);
    check("pub_valid_drop", 32'(tune_valid), 32'd0);
    check("pub_acc_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("pub_acc_word", 32'(acc_q[0]), 32'h01);

    // 2. bounces are ignored, a stable press yields one step
    acc_q.delete();
    repeat (3) begin
      btn2 = 1'b0;
      tick(2);
      btn2 = 1'b1;
      tick(2);
    end
    tick(10);
    check("bounce_pressed", 32'(pressed), 32'd0);
    check("bounce_no_offer", 32'(acc_q.size()), 32'd0);
    btn2 = 1'b0;
    tick(10);
    check("stable_pressed", 32'(pressed), 32'b10);
    btn2 = 1'b1;
    tick(12);
    check("press_offer_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("press_offer_word", 32'(acc_q[0]), 32'h02);
    check("press_released", 32'(pressed), 32'd0);

    // 3. hold into auto-repeat; hold length lands exactly five repeat steps
    acc_q.delete();
    btn2 = 1'b0;
    tick(50);
    check("repeat_shift_max", 32'(step_shift), 32'd3);
    check("repeat_mid_word", 32'(tune_word), 32'h12);
    btn2 = 1'b1;
    tick(15);
    check("repeat_count", 32'(acc_q.size()), 32'd6);
    if (acc_q.size() == 6) begin
      check("repeat_w0", 32'(acc_q[0]), 32'h03);
      check("repeat_w1", 32'(acc_q[1]), 32'h04);
      check("repeat_w2", 32'(acc_q[2]), 32'h06);
      check("repeat_w3", 32'(acc_q[3]), 32'h0A);
      check("repeat_w4", 32'(acc_q[4]), 32'h12);
      check("repeat_w5", 32'(acc_q[5]), 32'h1A);
    end
    check("repeat_shift_rel", 32'(step_shift), 32'd0);

    // 4. saturation at both ends
    do_reset();
    acc_q.delete();
    check("sat_lo_start", 32'(tune_word), 32'h01);
    btn1 = 1'b0;
    tick(60);
    btn1 = 1'b1;
    tick(15);
    check("sat_lo_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("sat_lo_word", 32'(acc_q[0]), 32'h00);
    check("sat_lo_final", 32'(tune_word), 32'h00);
    btn2 = 1'b0;
    tick(300);
    btn2 = 1'b1;
    tick(15);
    check("sat_hi_fill", 32'(tune_word), 32'hFF);
    press(1'b0);
    press(1'b0);
    check("sat_hi_fd", 32'(tune_word), 32'hFD);
    acc_q.delete();
    btn2 = 1'b0;
    tick(45);
    btn2 = 1'b1;
    tick(15);
    check("sat_hi_count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      check("sat_hi_w0", 32'(acc_q[0]), 32'hFE);
      check("sat_hi_w1", 32'(acc_q[1]), 32'hFF);
    end
    check("sat_hi_final", 32'(tune_word), 32'hFF);

    // 5. stalled handshake coalesces target updates
    do_reset();
    press(1'b1);
    press(1'b1);
    press(1'b1);
    check("stall_start", 32'(tune_word), 32'h04);
    tune_ready = 1'b0;
    press(1'b1);
    press(1'b1);
    press(1'b1);
    press(1'b1);
    check("stall_word", 32'(tune_word), 32'h05);
    check("stall_valid", 32'(tune_valid), 32'd1);
    acc_q.delete();
    tune_ready = 1'b1;
    tick(1);
    check("coalesce_valid", 32'(tune_valid), 32'd1);
    check("coalesce_word", 32'(tune_word), 32'h08);
    tick(1);
    check("coalesce_drop", 32'(tune_valid), 32'd0);
    check("coalesce_count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      check("coalesce_w0", 32'(acc_q[0]), 32'h05);
      check("coalesce_w1", 32'(acc_q[1]), 32'h08);
    end

    // 6. both buttons force zero, then nothing until release
    acc_q.delete();
    btn2 = 1'b0;
    tick(35);
    btn1 = 1'b0;
    tick(10);
    check("zero_word", 32'(tune_word), 32'h00);
    check("zero_shift", 32'(step_shift), 32'd0);
    tick(40);
    btn1 = 1'b1;
    btn2 = 1'b1;
    tick(15);
    check("zero_count", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() == 4) begin
      check("zero_w0", 32'(acc_q[0]), 32'h09);
      check("zero_w1", 32'(acc_q[1]), 32'h0A);
      check("zero_w2", 32'(acc_q[2]), 32'h0C);
      check("zero_w3", 32'(acc_q[3]), 32'h00);
    end

    // reset asserted in the middle of auto-repeat
    btn2 = 1'b0;
    tick(35);
    check("pre_rst_shift", 32'(step_shift), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_word", 32'(tune_word), 32'h01);
    check("mid_rst_valid", 32'(tune_valid), 32'd0);
    check("mid_rst_shift", 32'(step_shift), 32'd0);
    check("mid_rst_pressed", 32'(pressed), 32'd0);
    btn2 = 1'b1;
    tick(3);
    acc_q.delete();
    rst_n = 1'b1;
    tick(1);
    check("post_rst_valid", 32'(tune_valid), 32'd1);
    check("post_rst_word", 32'(tune_word), 32'h01);
    tick(20);
    check("post_rst_idle", 32'(acc_q.size()), 32'd1);
    check("post_rst_shift", 32'(step_shift), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
